// File: rtl/instr_queue_pkg.sv
// Shared fetch/queue/decode packet layout for the instruction queue.
package instr_queue_pkg;

  localparam int unsigned PACKET_SIZE = 65;

  // Field order fixes the bit layout: pc in the MSBs, taken_branch as the LSB.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        taken_branch;
  } fetched_packet_t;

endpackage

// File: rtl/instr_queue.sv
// Dual-entry-wide circular instruction buffer between fetch and decode.
// Fetch writes a pair per cycle, decode reads the two oldest entries
// and may retire 0, 1 or 2 of them per cycle.
module instr_queue #(
  parameter int unsigned PACKET_SIZE = instr_queue_pkg::PACKET_SIZE,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [2*PACKET_SIZE-1:0]   push_data,
  input  logic                       push_valid,
  output logic                       ready_o,
  output logic [PACKET_SIZE-1:0]     head_a,
  output logic [PACKET_SIZE-1:0]     head_b,
  output logic                       valid_a,
  output logic                       valid_b,
  input  logic                       pop_a,
  input  logic                       pop_b,
  output logic [$clog2(DEPTH):0]     count
);

  import instr_queue_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PACKET_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [CW-1:0]          count_q;

  logic [PACKET_SIZE-1:0] packet_a;
  logic [PACKET_SIZE-1:0] packet_b;
  logic                   push_acc;
  logic [1:0]             pop_n;

  assign packet_a = push_data[PACKET_SIZE-1:0];
  assign packet_b = push_data[2*PACKET_SIZE-1:PACKET_SIZE];

  // Status decoded only from registered occupancy, so a same-cycle pop
  // can never combinationally raise ready_o.
  assign count   = count_q;
  assign valid_a = (count_q != '0);
  assign valid_b = (count_q >= CW'(2));
  assign ready_o = (count_q <= CW'(DEPTH - 2));

  assign head_a  = mem[head];
  assign head_b  = mem[head + PW'(1)];

  assign push_acc = push_valid & ready_o & ~flush;

  // Number of entries retired this cycle; pop_b only counts alongside pop_a.
  always_comb begin
    pop_n = 2'd0;
    if (pop_a && valid_a) begin
      if (pop_b && valid_b) pop_n = 2'd2;
      else                  pop_n = 2'd1;
    end
  end

  // Pair write into storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[tail]          <= packet_a;
      mem[tail + PW'(1)] <= packet_b;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(pop_n);
      if (push_acc) tail <= tail + PW'(2);
      count_q <= count_q + CW'({push_acc, 1'b0}) - CW'(pop_n);
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CW'(DEPTH));

  a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
    (count_q < CW'(DEPTH)) |-> ((head + PW'(count_q)) == tail));

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue against a queue-based reference model.
module tb_instr_queue;
  import instr_queue_pkg::*;

  localparam int unsigned PS    = PACKET_SIZE;
  localparam int unsigned DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [2*PS-1:0]   push_data = '0;
  logic              push_valid = 1'b0;
  logic              ready_o;
  logic [PS-1:0]     head_a, head_b;
  logic              valid_a, valid_b;
  logic              pop_a = 1'b0, pop_b = 1'b0;
  logic [3:0]        count;

  instr_queue #(.PACKET_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_data(push_data),
    .push_valid(push_valid), .ready_o(ready_o), .head_a(head_a),
    .head_b(head_b), .valid_a(valid_a), .valid_b(valid_b),
    .pop_a(pop_a), .pop_b(pop_b), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          va, vb, rdy;
    int          cnt;
    logic [PS-1:0] ha, hb;
  } exp_t;

  exp_t          exp_q[$];
  logic [PS-1:0] model[$];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [PS-1:0] mk(input logic [31:0] pc, input logic [31:0] data,
                                       input logic tb);
    fetched_packet_t p;
    p.pc = pc; p.data = data; p.taken_branch = tb;
    return p;
  endfunction

  // Snapshot expected outputs from the model, drive inputs, then advance the model.
  task automatic step(input logic r, input logic f, input logic pv,
                      input logic [PS-1:0] a, input logic [PS-1:0] b,
                      input logic pa, input logic pb);
    exp_t e;
    int   n;
    bit   acc;
    @(posedge clk); #1;
    e.cnt = model.size();
    e.va  = (model.size() >= 1);
    e.vb  = (model.size() >= 2);
    e.rdy = (DEPTH - model.size() >= 2);
    e.ha  = e.va ? model[0] : '0;
    e.hb  = e.vb ? model[1] : '0;
    exp_q.push_back(e);
    rst = r; flush = f; push_valid = pv; push_data = {b, a}; pop_a = pa; pop_b = pb;
    if (r || f) begin
      model.delete();
    end else begin
      n = 0;
      if (pa && model.size() >= 1) n = (pb && model.size() >= 2) ? 2 : 1;
      acc = pv && (DEPTH - model.size() >= 2);
      repeat (n) void'(model.pop_front());
      if (acc) begin
        model.push_back(a);
        model.push_back(b);
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic push2(input logic [31:0] pc);
    step(0, 0, 1, mk(pc, pc ^ 32'hA5A5_0000, 1'b0), mk(pc + 4, pc ^ 32'h5A5A_0000, 1'b1), 0, 0);
  endtask

  task automatic check(input string name, input logic [PS-1:0] act, input logic [PS-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count",   PS'(count),   PS'(e.cnt));
        check("valid_a", PS'(valid_a), PS'(e.va));
        check("valid_b", PS'(valid_b), PS'(e.vb));
        check("ready_o", PS'(ready_o), PS'(e.rdy));
        if (e.va) check("head_a", head_a, e.ha);
        if (e.vb) check("head_b", head_b, e.hb);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;
    // reset for two cycles, then idle
    step(1, 0, 0, '0, '0, 0, 0);
    step(1, 0, 0, '0, '0, 0, 0);
    idle();
    // single pair
    push2(32'h100);
    idle();
    // fill to DEPTH, then a dropped push
    push2(32'h108);
    push2(32'h110);
    push2(32'h118);
    push2(32'h120);
    idle();
    // pop_b alone is ignored
    step(0, 0, 0, '0, '0, 0, 1);
    // drain to count 3 with head at 5
    step(0, 0, 0, '0, '0, 1, 1);
    step(0, 0, 0, '0, '0, 1, 1);
    step(0, 0, 0, '0, '0, 1, 0);
    // pop 2 + push 2 at count 3, twice, crossing head 7 -> 0
    step(0, 0, 1, mk(32'h300, 32'h1, 1'b0), mk(32'h304, 32'h2, 1'b1), 1, 1);
    step(0, 0, 1, mk(32'h308, 32'h3, 1'b1), mk(32'h30C, 32'h4, 1'b0), 1, 1);
    idle();
    // count 3 -> 1 -> 0 with dual pops
    step(0, 0, 0, '0, '0, 1, 1);
    step(0, 0, 0, '0, '0, 1, 1);
    step(0, 0, 0, '0, '0, 1, 1);
    // count 2, pop_b alone
    push2(32'h400);
    step(0, 0, 0, '0, '0, 0, 1);
    // count 6, flush with push and pop
    push2(32'h408);
    push2(32'h410);
    step(0, 1, 1, mk(32'h500, 32'h0, 1'b0), mk(32'h504, 32'h0, 1'b0), 1, 1);
    push2(32'h200);
    idle();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      pc = $urandom;
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 9) < 6),
           mk(pc, $urandom, 1'($urandom)), mk(pc + 4, $urandom, 1'($urandom)),
           1'($urandom), 1'($urandom));
    end
    idle();
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
